wm_seq_ctrl: RTL and testbench

WM_SEQ_CTRL -- requirements
Module: wm_seq_ctrl

---
 rtl/wm_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wm_seq_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_seq_ctrl.sv
// Verification sequencer for a watermark FSM: drives a reset pulse, replays a stored
// init symbol pattern, then checks LEN_O-bit responses against an MD5-derived signature.
module wm_seq_ctrl #(
  parameter int LEN_I   = 3,
  parameter int LEN_O   = 5,
  parameter int MAX_INI = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             start,
  input  logic [8:0]       init_clock,
  output logic             dut_rst,
  output logic [LEN_I-1:0] dut_in,
  input  logic [LEN_O-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count
);

  localparam int MAX_SYM = MAX_INI / LEN_I;
  localparam int PAIR_W  = LEN_I + LEN_O;
  localparam int P       = 128 / PAIR_W;
  localparam int CNT_W   = $clog2(MAX_SYM + 1);
  localparam int PCNT_W  = $clog2(P + 1);
  localparam int PTR_W   = $clog2(MAX_INI);
  localparam int N_WORDS = MAX_INI / 32;

  typedef enum logic [2:0] {IDLE, DRST, INIT, CHECK, DONE} state_t;

  state_t             state;
  state_t             state_nxt;

  logic [MAX_INI-1:0] pattern;
  logic [127:0]       md5;
  logic [CNT_W-1:0]   n_sym;
  logic [CNT_W-1:0]   sym_cnt;
  logic [CNT_W-1:0]   n_start;
  logic [PCNT_W-1:0]  pair_cnt;
  logic [PTR_W-1:0]   bit_ptr;
  logic [6:0]         md_ptr;
  logic [6:0]         exp_ptr;
  logic [LEN_O-1:0]   exp_sym;
  logic               accept;
  logic               cfg_ok;
  logic               init_last;
  logic               check_last;
  logic               mismatch;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  assign n_start    = (32'(init_clock) > 32'(MAX_SYM)) ? CNT_W'(MAX_SYM) : CNT_W'(init_clock);
  assign accept     = (state == IDLE) && start;
  assign cfg_ok     = (state == IDLE) && cfg_we;
  assign init_last  = (sym_cnt == n_sym - CNT_W'(1));
  assign check_last = (pair_cnt == PCNT_W'(P - 1));
  assign exp_ptr    = md_ptr - 7'(LEN_I);
  assign exp_sym    = md5[exp_ptr -: LEN_O];
  // Case inequality so an undriven/X response from the FSM under test counts as a miss.
  assign mismatch   = (dut_out !== exp_sym);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dut_rst   = 1'b0;
    dut_in    = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = DRST;
      end
      DRST: begin
        dut_rst   = 1'b1;
        state_nxt = (n_sym != '0) ? INIT : CHECK;
      end
      INIT: begin
        dut_in = pattern[bit_ptr +: LEN_I];
        if (init_last) state_nxt = CHECK;
      end
      CHECK: begin
        dut_in = md5[md_ptr -: LEN_I];
        if (check_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Pattern is replayed newest-symbol-last, so the pointer walks down from the top symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern   <= '0;
      md5       <= '0;
      n_sym     <= '0;
      sym_cnt   <= '0;
      pair_cnt  <= '0;
      bit_ptr   <= '0;
      md_ptr    <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      if (cfg_ok) begin
        if (32'(cfg_addr) < 32'(N_WORDS)) begin
          pattern[32'(cfg_addr) * 32 +: 32] <= cfg_wdata;
        end
        if (cfg_addr[5:2] == 4'b1000) begin
          md5[{cfg_addr[1:0], 5'd0} +: 32] <= cfg_wdata;
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            n_sym     <= n_start;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        DRST: begin
          sym_cnt  <= '0;
          pair_cnt <= '0;
          bit_ptr  <= PTR_W'((32'(n_sym) - 32'd1) * 32'(LEN_I));
          md_ptr   <= 7'd127;
        end
        INIT: begin
          if (!init_last) sym_cnt <= sym_cnt + CNT_W'(1);
          bit_ptr <= bit_ptr - PTR_W'(LEN_I);
        end
        CHECK: begin
          if (mismatch) err_count <= sat_inc(err_count);
          md_ptr <= md_ptr - 7'(PAIR_W);
          if (!check_last) pair_cnt <= pair_cnt + PCNT_W'(1);
        end
        DONE: begin
          pass <= (err_count == 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wm_seq_ctrl.sv
// Self-checking bench for wm_seq_ctrl: scoreboard of expected dut_in symbols and run
// results, plus a behavioural model of the watermark FSM that can inject bad responses.
module tb_wm_seq_ctrl;

  localparam int LEN_I   = 3;
  localparam int LEN_O   = 5;
  localparam int MAX_SYM = 341;
  localparam int P       = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [5:0]       cfg_addr = '0;
  logic [31:0]      cfg_wdata = '0;
  logic             start = 1'b0;
  logic [8:0]       init_clock = '0;
  logic             dut_rst;
  logic [LEN_I-1:0] dut_in;
  logic [LEN_O-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [4:0]       err_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1023:0]    pat_m = '0;
  logic [127:0]     md5_m = '0;
  logic [LEN_I-1:0] sb_q[$];
  logic [4:0]       res_q[$];
  logic [LEN_I-1:0] mon_sym;
  logic [4:0]       mon_res;
  int               m_n = 0;
  int               run_cyc = 1000;
  logic [15:0]      bad_mask = '0;
  bit               bad_x = 1'b0;
  int               exp_err = 0;

  wm_seq_ctrl #(.LEN_I(LEN_I), .LEN_O(LEN_O), .MAX_INI(1024)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .init_clock(init_clock), .dut_rst(dut_rst), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Cycle index since the DUT reset pulse: k during INIT cycle k, N+j during CHECK pair j.
  always @(posedge clk) begin
    if (dut_rst) run_cyc <= 0;
    else         run_cyc <= run_cyc + 1;
  end

  always_comb begin
    dut_out = '0;
    if (busy && !dut_rst && !done && run_cyc >= m_n && run_cyc < m_n + P) begin
      if (bad_mask[run_cyc - m_n]) dut_out = bad_x ? 5'b1xxxx : 5'h1F;
    end
  end

  always @(negedge clk) begin
    if (!reset && busy) begin
      if (dut_rst || done) begin
        tests_run++;
        if (dut_in !== '0) begin
          tests_failed++;
          $display("FAIL mon_dut_in_idle got %0h want 0", dut_in);
        end
      end
      if (dut_rst) begin
        tests_run++;
        if (pass !== 1'b0 || err_count !== 5'd0) begin
          tests_failed++;
          $display("FAIL mon_start_clear got pass=%0b err=%0d want pass=0 err=0", pass, err_count);
        end
      end
      if (!dut_rst && !done) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL mon_sb_underflow got symbol %0h want none", dut_in);
        end else begin
          mon_sym = sb_q.pop_front();
          if (dut_in !== mon_sym) begin
            tests_failed++;
            $display("FAIL mon_dut_in got %0h want %0h", dut_in, mon_sym);
          end
        end
      end
      if (done) begin
        tests_run++;
        if (res_q.size() == 0) begin
          tests_failed++;
          $display("FAIL mon_res_underflow got err=%0d want none", err_count);
        end else begin
          mon_res = res_q.pop_front();
          if (err_count !== mon_res) begin
            tests_failed++;
            $display("FAIL mon_err_count got %0d want %0d", err_count, mon_res);
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a < 6'd32) pat_m[a * 32 +: 32] = d;
    else if (a < 6'd36) md5_m[(a - 32) * 32 +: 32] = d;
  endtask

  task automatic push_expected(input int ic);
    int n;
    int cnt;
    logic [4:0] ev;
    n = (ic > MAX_SYM) ? MAX_SYM : ic;
    m_n = n;
    for (int k = 0; k < n; k++) sb_q.push_back(pat_m[(n - 1 - k) * LEN_I +: LEN_I]);
    cnt = 0;
    for (int j = 0; j < P; j++) begin
      sb_q.push_back(md5_m[127 - j * 8 -: LEN_I]);
      ev = md5_m[127 - LEN_I - j * 8 -: LEN_O];
      if (bad_mask[j]) begin
        if (bad_x || ev != 5'h1F) cnt++;
      end else if (ev != 5'h00) begin
        cnt++;
      end
    end
    exp_err = (cnt > 31) ? 31 : cnt;
    res_q.push_back(5'(exp_err));
  endtask

  task automatic do_run(input int ic, input bit poke, output int busy_cyc, output int s2d,
                        output int rst_cyc);
    int c;
    bit seen;
    push_expected(ic);
    busy_cyc = 0; s2d = 0; rst_cyc = 0; seen = 1'b0;
    init_clock = 9'(ic);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!seen && c < ic + 200) begin
      @(negedge clk);
      c++;
      if (busy) busy_cyc++;
      if (dut_rst) rst_cyc++;
      if (done) begin
        seen = 1'b1;
        s2d  = c;
      end else begin
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        if (poke && c == m_n + 4) begin
          cfg_we = 1'b1; cfg_addr = 6'd33; cfg_wdata = '1; start = 1'b1;
        end
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL run_timeout got no done after %0d cycles want done", c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got %0b want 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL rst_pass got %0b want 0", pass); end
    tests_run++; if (err_count !== 5'd0) begin tests_failed++; $display("FAIL rst_err got %0d want 0", err_count); end
    tests_run++; if (dut_in !== 3'd0) begin tests_failed++; $display("FAIL rst_dut_in got %0h want 0", dut_in); end
    tests_run++; if (dut_rst !== 1'b0) begin tests_failed++; $display("FAIL rst_dut_rst got %0b want 0", dut_rst); end
  endtask

  task automatic test_basic();
    int b, s, r;
    cfg_write(6'd0, 32'h0000_0005);
    bad_mask = '0; bad_x = 1'b0;
    do_run(2, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (s != 20) begin tests_failed++; $display("FAIL basic_start_to_done got %0d want 20", s); end
    tests_run++; if (b != 20) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d want 20", b); end
    tests_run++; if (r != 1) begin tests_failed++; $display("FAIL basic_dut_rst_cycles got %0d want 1", r); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL basic_pass got %0b want 1", pass); end
    tests_run++; if (err_count !== 5'd0) begin tests_failed++; $display("FAIL basic_err got %0d want 0", err_count); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL basic_idle got busy=%0b done=%0b want 0 0", busy, done); end
    tests_run++; if (sb_q.size() != 0) begin tests_failed++; $display("FAIL basic_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_errors();
    int b, s, r;
    bad_mask = 16'h0088; bad_x = 1'b0;
    do_run(2, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (err_count !== 5'd2) begin tests_failed++; $display("FAIL errors_err got %0d want 2", err_count); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL errors_pass got %0b want 0", pass); end
    tests_run++; if (b != 20) begin tests_failed++; $display("FAIL errors_busy_cycles got %0d want 20", b); end
  endtask

  task automatic test_back_to_back();
    int b, s, r;
    bad_mask = 16'h0088;
    do_run(2, 1'b0, b, s, r);
    bad_mask = '0;
    do_run(2, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (err_count !== 5'd0) begin tests_failed++; $display("FAIL b2b_err got %0d want 0", err_count); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL b2b_pass got %0b want 1", pass); end
  endtask

  task automatic test_zero_init();
    int b, s, r;
    bad_mask = '0;
    do_run(0, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (b != 18) begin tests_failed++; $display("FAIL zero_busy_cycles got %0d want 18", b); end
    tests_run++; if (r != 1) begin tests_failed++; $display("FAIL zero_dut_rst_cycles got %0d want 1", r); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL zero_pass got %0b want 1", pass); end
  endtask

  task automatic test_max_init();
    int b, s, r;
    for (int w = 0; w < 36; w++) cfg_write(6'(w), $urandom());
    bad_mask = '0;
    do_run(400, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (b != 359) begin tests_failed++; $display("FAIL max_busy_cycles got %0d want 359", b); end
    tests_run++; if (err_count !== 5'(exp_err)) begin tests_failed++; $display("FAIL max_err got %0d want %0d", err_count, exp_err); end
    tests_run++; if (pass !== (exp_err == 0)) begin tests_failed++; $display("FAIL max_pass got %0b want %0b", pass, exp_err == 0); end
    tests_run++; if (sb_q.size() != 0) begin tests_failed++; $display("FAIL max_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_busy_ignore();
    int b, s, r;
    cfg_write(6'd33, 32'h0000_0000);
    do_run(3, 1'b1, b, s, r);
    @(negedge clk);
    tests_run++; if (b != 21) begin tests_failed++; $display("FAIL ign_busy_cycles got %0d want 21", b); end
    tests_run++; if (err_count !== 5'(exp_err)) begin tests_failed++; $display("FAIL ign_err got %0d want %0d", err_count, exp_err); end
    do_run(3, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (err_count !== 5'(exp_err)) begin tests_failed++; $display("FAIL ign_rerun_err got %0d want %0d", err_count, exp_err); end
    tests_run++; if (sb_q.size() != 0) begin tests_failed++; $display("FAIL ign_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int b, s, r;
    push_expected(10);
    init_clock = 9'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %0b want 0", busy); end
    tests_run++; if (dut_in !== 3'd0) begin tests_failed++; $display("FAIL midrst_dut_in got %0h want 0", dut_in); end
    tests_run++; if (dut_rst !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL midrst_pulses got rst=%0b done=%0b want 0 0", dut_rst, done); end
    tests_run++; if (err_count !== 5'd0 || pass !== 1'b0) begin tests_failed++; $display("FAIL midrst_result got err=%0d pass=%0b want 0 0", err_count, pass); end
    sb_q.delete();
    res_q.delete();
    pat_m = '0;
    md5_m = '0;
    // reset still high: start and config write in the same cycle must lose
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = '1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_prio_busy got %0b want 0", busy); end
    bad_mask = '0;
    do_run(4, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL cleared_store_pass got %0b want 1", pass); end
    tests_run++; if (sb_q.size() != 0) begin tests_failed++; $display("FAIL cleared_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_x_pair();
    int b, s, r;
    bad_mask = 16'h0020; bad_x = 1'b1;
    do_run(1, 1'b0, b, s, r);
    @(negedge clk);
    tests_run++; if (err_count !== 5'd1) begin tests_failed++; $display("FAIL xpair_err got %0d want 1", err_count); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL xpair_pass got %0b want 0", pass); end
    bad_mask = '0; bad_x = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_errors();
    test_back_to_back();
    test_zero_init();
    test_max_init();
    test_busy_ignore();
    test_reset_mid_run();
    test_x_pair();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
